// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for the trex runner.
//   Synchronises and debounces the raw jump button, runs the
//   IDLE/RUN/CRASH state machine, generates speed/jump/crash/game_rst for the
//   trex and obstacle blocks, and keeps a frame-based score.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per video frame
//   btn        in   raw asynchronous jump/start button, active high
//   collision  in   trex overlaps obstacle (level)
//   speed      out  [3:0]  game speed
//   jump       out  one-cycle jump pulse
//   crash      out  game-over level
//   game_rst   out  one-cycle restart pulse
//   score      out  [13:0] binary score 0..9999
//   state      out  [1:0]  0=IDLE 1=RUN 2=CRASH
//   hiscore    out  [13:0] best score (only with GAME_CTRL_HISCORE_EN)
//
// Optional feature macro: GAME_CTRL_HISCORE_EN adds the hiscore register/port.

module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCORE_DIV       = 6,
  parameter int SPEED_INIT      = 6,
  parameter int SPEED_MAX       = 13,
  parameter int SPEED_STEP      = 100,
  parameter int CRASH_HOLD      = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn,
  input  logic        collision,
  output logic [3:0]  speed,
  output logic        jump,
  output logic        crash,
  output logic        game_rst,
  output logic [13:0] score,
  output logic [1:0]  state
`ifdef GAME_CTRL_HISCORE_EN
  ,
  output logic [13:0] hiscore
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FR_W = $clog2(SCORE_DIV + 1);
  localparam int ST_W = $clog2(SPEED_STEP + 1);
  localparam int HD_W = $clog2(CRASH_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CRASH = 2'd2
  } state_t;

  state_t            cur_state;
  logic              btn_meta;
  logic              btn_sync;
  logic [DB_W-1:0]   db_cnt;
  logic              db_level;
  logic              db_prev;
  logic              press_evt;
  logic [FR_W-1:0]   frame_cnt;
  logic [ST_W-1:0]   step_cnt;
  logic [HD_W-1:0]   hold_cnt;

  assign state     = cur_state;
  // db_prev lags db_level by one cycle, so a held button yields one event.
  assign press_evt = db_level & ~db_prev;

  // Button synchroniser and debounce filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      db_prev  <= db_level;
      if (btn_sync != db_level) begin
        // Accept the new level on the last of DEBOUNCE_CYCLES differing cycles.
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= btn_sync;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Game state machine with registered control outputs and score keeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      speed     <= 4'd0;
      jump      <= 1'b0;
      crash     <= 1'b0;
      game_rst  <= 1'b0;
      score     <= 14'd0;
      frame_cnt <= '0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
`ifdef GAME_CTRL_HISCORE_EN
      hiscore   <= 14'd0;
`endif
    end else begin
      jump     <= 1'b0;
      game_rst <= 1'b0;
      case (cur_state)
        S_IDLE: begin
          crash <= 1'b0;
          if (press_evt) begin
            cur_state <= S_RUN;
            game_rst  <= 1'b1;
            speed     <= 4'(SPEED_INIT);
            score     <= 14'd0;
            frame_cnt <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
          end else begin
            speed <= 4'd0;
          end
        end
        S_RUN: begin
          if (collision) begin
            // Collision wins over any coincident press or frame tick.
            cur_state <= S_CRASH;
            crash     <= 1'b1;
            speed     <= 4'd0;
            hold_cnt  <= '0;
`ifdef GAME_CTRL_HISCORE_EN
            if (score > hiscore) begin
              hiscore <= score;
            end
`endif
          end else begin
            if (press_evt) begin
              jump <= 1'b1;
            end
            if (frame_tick) begin
              if (frame_cnt == FR_W'(SCORE_DIV - 1)) begin
                frame_cnt <= '0;
                score     <= (score == 14'd9999) ? 14'd0 : score + 14'd1;
                if (step_cnt == ST_W'(SPEED_STEP - 1)) begin
                  step_cnt <= '0;
                  if (speed < 4'(SPEED_MAX)) begin
                    speed <= speed + 4'd1;
                  end
                end else begin
                  step_cnt <= step_cnt + ST_W'(1);
                end
              end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
              end
            end
          end
        end
        S_CRASH: begin
          if (press_evt && (hold_cnt == HD_W'(CRASH_HOLD))) begin
            cur_state <= S_RUN;
            game_rst  <= 1'b1;
            crash     <= 1'b0;
            speed     <= 4'(SPEED_INIT);
            score     <= 14'd0;
            frame_cnt <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
          end else begin
            crash <= 1'b1;
            speed <= 4'd0;
            if (frame_tick && (hold_cnt != HD_W'(CRASH_HOLD))) begin
              hold_cnt <= hold_cnt + HD_W'(1);
            end
          end
        end
        default: begin
          // Encoding 3 is not a legal state; recover to IDLE.
          cur_state <= S_IDLE;
          speed     <= 4'd0;
          crash     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed, scoreboard-based bench for game_ctrl.
//   dut_a uses small debounce/score/step/hold values for the main scenarios;
//   dut_b uses SCORE_DIV=1 for the score wrap and mid-game reset checks.

module tb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, frame_tick_a, btn_a, collision_a;
  logic [3:0]  speed_a;
  logic        jump_a, crash_a, game_rst_a;
  logic [13:0] score_a;
  logic [1:0]  state_a;
  logic        rst_b, frame_tick_b, btn_b, collision_b;
  logic [3:0]  speed_b;
  logic        jump_b, crash_b, game_rst_b;
  logic [13:0] score_b;
  logic [1:0]  state_b;
`ifdef GAME_CTRL_HISCORE_EN
  logic [13:0] hiscore_a, hiscore_b;
`endif

  game_ctrl #(.DEBOUNCE_CYCLES(4), .SCORE_DIV(2), .SPEED_INIT(6), .SPEED_MAX(8),
              .SPEED_STEP(3), .CRASH_HOLD(2)) dut_a (
    .clk(clk), .rst(rst_a), .frame_tick(frame_tick_a), .btn(btn_a),
    .collision(collision_a), .speed(speed_a), .jump(jump_a), .crash(crash_a),
    .game_rst(game_rst_a), .score(score_a), .state(state_a)
`ifdef GAME_CTRL_HISCORE_EN
    , .hiscore(hiscore_a)
`endif
  );

  game_ctrl #(.DEBOUNCE_CYCLES(4), .SCORE_DIV(1), .SPEED_INIT(6), .SPEED_MAX(8),
              .SPEED_STEP(3), .CRASH_HOLD(2)) dut_b (
    .clk(clk), .rst(rst_b), .frame_tick(frame_tick_b), .btn(btn_b),
    .collision(collision_b), .speed(speed_b), .jump(jump_b), .crash(crash_b),
    .game_rst(game_rst_b), .score(score_b), .state(state_b)
`ifdef GAME_CTRL_HISCORE_EN
    , .hiscore(hiscore_b)
`endif
  );

  // Pulse counters for dut_a, sampled mid-cycle.
  int n_rst_a  = 0;
  int n_jump_a = 0;
  int n_both_a = 0;
  always @(negedge clk) begin
    if (game_rst_a === 1'b1) n_rst_a <= n_rst_a + 1;
    if (jump_a === 1'b1) n_jump_a <= n_jump_a + 1;
    if (jump_a === 1'b1 && game_rst_a === 1'b1) n_both_a <= n_both_a + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic sb_exp(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sbq.push_back(it);
  endtask

  task automatic sb_chk(input logic [31:0] obs);
    sb_item_t it;
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      it = sbq.pop_front();
      assert (obs === it.exp) else begin
        mismatched++;
        $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick_a();
    frame_tick_a = 1'b1;
    tick();
    frame_tick_a = 1'b0;
    tick();
  endtask

  // Bounded waits; a timeout shows up as a state mismatch afterwards.
  task automatic wait_a(input logic [1:0] s);
    for (int i = 0; i < 40 && state_a !== s; i++) tick();
  endtask

  task automatic wait_b(input logic [1:0] s);
    for (int i = 0; i < 40 && state_b !== s; i++) tick();
  endtask

  initial begin
    rst_a = 1'b1; frame_tick_a = 1'b0; btn_a = 1'b0; collision_a = 1'b0;
    rst_b = 1'b1; frame_tick_b = 1'b0; btn_b = 1'b0; collision_b = 1'b0;

    // 1. Reset values
    sb_exp("rst_state", 0); sb_exp("rst_speed", 0); sb_exp("rst_jump", 0);
    sb_exp("rst_crash", 0); sb_exp("rst_game_rst", 0); sb_exp("rst_score", 0);
    repeat (3) tick();
    sb_chk(state_a); sb_chk(speed_a); sb_chk(jump_a);
    sb_chk(crash_a); sb_chk(game_rst_a); sb_chk(score_a);
`ifdef GAME_CTRL_HISCORE_EN
    sb_exp("rst_hiscore", 0); sb_chk(hiscore_a);
`endif
    rst_a = 1'b0;

    // Glitch shorter than the debounce window
    sb_exp("glitch_state", 0); sb_exp("glitch_game_rst_pulses", 0);
    btn_a = 1'b1; repeat (2) tick(); btn_a = 1'b0; repeat (10) tick();
    sb_chk(state_a); sb_chk(n_rst_a);

    // Start press
    sb_exp("start_state", 1); sb_exp("start_game_rst", 1); sb_exp("start_speed", 6);
    sb_exp("start_score", 0); sb_exp("start_jump", 0); sb_exp("start_crash", 0);
    btn_a = 1'b1; wait_a(2'd1);
    sb_chk(state_a); sb_chk(game_rst_a); sb_chk(speed_a);
    sb_chk(score_a); sb_chk(jump_a); sb_chk(crash_a);
    sb_exp("start_single_pulse", 1); sb_exp("start_no_jump", 0);
    repeat (12) tick(); btn_a = 1'b0; repeat (10) tick();
    sb_chk(n_rst_a); sb_chk(n_jump_a);

    // 2. Scoring and speed stepping
    sb_exp("score_6t", 3); sb_exp("speed_6t", 7);
    repeat (6) ftick_a();
    sb_chk(score_a); sb_chk(speed_a);
    sb_exp("score_18t", 9); sb_exp("speed_18t", 8);
    repeat (12) ftick_a();
    sb_chk(score_a); sb_chk(speed_a);
    sb_exp("score_24t", 12); sb_exp("speed_sat", 8);
    repeat (6) ftick_a();
    sb_chk(score_a); sb_chk(speed_a);

    // 3. Jump pulses
    sb_exp("jump_first", 1);
    btn_a = 1'b1; repeat (20) tick();
    sb_chk(n_jump_a);
    btn_a = 1'b0; repeat (10) tick();
    sb_exp("jump_second", 2);
    btn_a = 1'b1; repeat (20) tick();
    sb_chk(n_jump_a);
    btn_a = 1'b0; repeat (10) tick();
    sb_exp("jump_score_kept", 12); sb_exp("jump_state_run", 1);
    sb_chk(score_a); sb_chk(state_a);

    // Mid-game reset, then a fresh game up to score 5
    sb_exp("abort_state", 0); sb_exp("abort_speed", 0); sb_exp("abort_score", 0);
    rst_a = 1'b1; tick();
    sb_chk(state_a); sb_chk(speed_a); sb_chk(score_a);
    rst_a = 1'b0; tick();
    sb_exp("restart2_state", 1);
    btn_a = 1'b1; wait_a(2'd1);
    sb_chk(state_a);
    btn_a = 1'b0; repeat (10) tick();
    sb_exp("pre_crash_score", 5); sb_exp("pre_crash_speed", 7);
    repeat (11) ftick_a();
    sb_chk(score_a); sb_chk(speed_a);

    // 4. Collision coincident with frame_tick and press_evt
    btn_a = 1'b1; repeat (6) tick();   // press_evt is high in this cycle
    sb_exp("crash_state", 2); sb_exp("crash_level", 1); sb_exp("crash_score", 5);
    sb_exp("crash_speed", 0); sb_exp("crash_jump", 0);
    collision_a = 1'b1; frame_tick_a = 1'b1; tick();
    collision_a = 1'b0; frame_tick_a = 1'b0;
    sb_chk(state_a); sb_chk(crash_a); sb_chk(score_a); sb_chk(speed_a); sb_chk(jump_a);
    sb_exp("crash_no_jump_pulse", 2);
    repeat (3) tick();
    sb_chk(n_jump_a);
`ifdef GAME_CTRL_HISCORE_EN
    sb_exp("hiscore_first", 5); sb_chk(hiscore_a);
`endif

    // 5. Restart hold
    btn_a = 1'b0; repeat (10) tick();
    ftick_a();
    sb_exp("hold_crash", 1); sb_exp("hold_state", 2); sb_exp("hold_no_restart", 2);
    btn_a = 1'b1; repeat (20) tick();
    sb_chk(crash_a); sb_chk(state_a); sb_chk(n_rst_a);
    btn_a = 1'b0; repeat (10) tick();
    ftick_a();
    sb_exp("restart_state", 1); sb_exp("restart_game_rst", 1); sb_exp("restart_crash", 0);
    sb_exp("restart_score", 0); sb_exp("restart_speed", 6);
    btn_a = 1'b1; wait_a(2'd1);
    sb_chk(state_a); sb_chk(game_rst_a); sb_chk(crash_a); sb_chk(score_a); sb_chk(speed_a);
    btn_a = 1'b0; repeat (10) tick();
    sb_exp("second_run_score", 2);
    repeat (4) ftick_a();
    sb_chk(score_a);
    sb_exp("second_crash_state", 2);
    collision_a = 1'b1; tick(); collision_a = 1'b0;
    sb_chk(state_a);
`ifdef GAME_CTRL_HISCORE_EN
    sb_exp("hiscore_kept", 5); sb_chk(hiscore_a);
`endif
    sb_exp("never_jump_and_game_rst", 0); sb_exp("total_game_rst_pulses", 3);
    tick();
    sb_chk(n_both_a); sb_chk(n_rst_a);

    // 6. Score wrap on dut_b (one point per frame_tick)
    rst_b = 1'b0; tick();
    sb_exp("b_start_state", 1);
    btn_b = 1'b1; wait_b(2'd1);
    sb_chk(state_b);
    btn_b = 1'b0; repeat (10) tick();
    sb_exp("b_score_9999", 9999);
    frame_tick_b = 1'b1;
    repeat (9999) tick();
    sb_chk(score_b);
    sb_exp("b_score_wrap", 0); sb_exp("b_jump", 0); sb_exp("b_crash", 0); sb_exp("b_game_rst", 0);
    tick();
    frame_tick_b = 1'b0;
    sb_chk(score_b); sb_chk(jump_b); sb_chk(crash_b); sb_chk(game_rst_b);
    sb_exp("b_abort_state", 0); sb_exp("b_abort_speed", 0); sb_exp("b_abort_score", 0);
    frame_tick_b = 1'b1; repeat (5) tick();
    rst_b = 1'b1; tick();
    frame_tick_b = 1'b0;
    sb_chk(state_b); sb_chk(speed_b); sb_chk(score_b);
`ifdef GAME_CTRL_HISCORE_EN
    sb_exp("b_hiscore", 0); sb_chk(hiscore_b);
`endif
    rst_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
